gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/bp_pkg.sv | 29 ++
 rtl/sat_counter2.sv | 22 ++
 rtl/gshare_predictor.sv | 99 +++++++++
 tb/tb_gshare_predictor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare branch predictor.
package bp_pkg;

    localparam int BHSR_WIDTH_DEF = 5;

    // Tag storage is sized for the smallest legal history (pc[31:2]);
    // wider histories leave the upper tag bits zero.
    localparam int TAG_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             is_jump;
    } btb_entry_t;

    // Upper PC bits above the index field, zero-extended to TAG_W.
    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc, input int hist_w);
        return TAG_W'(pc >> (hist_w + 2));
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter step: move towards taken or not-taken, clamp at the ends.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_t cnt_i,
    input  logic taken_i,
    output ctr_t cnt_o
);

    // Next counter value for one resolved outcome.
    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            SNT: cnt_o = taken_i ? WNT : SNT;
            WNT: cnt_o = taken_i ? WT  : SNT;
            WT:  cnt_o = taken_i ? ST  : WNT;
            ST:  cnt_o = taken_i ? ST  : WT;
            default: cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (history-XOR-indexed PHT) with a direct-mapped BTB.
// Prediction is purely combinational over the registered tables, so an update
// in the same cycle is only visible from the following cycle.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int BHSR_WIDTH = BHSR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_if,
    input  logic [BHSR_WIDTH-1:0] bhsr_in,
    output logic                  pred_taken,
    output logic [31:0]           next_pc,
    input  logic                  upd_en,
    input  logic [31:0]           upd_pc,
    input  logic [BHSR_WIDTH-1:0] upd_bhsr,
    input  logic                  upd_taken,
    input  logic [31:0]           upd_target,
    input  logic                  upd_is_jump,
    output logic                  bhsr_upd_en,
    output logic                  bhsr_taken
);

    localparam int ENTRIES = 1 << BHSR_WIDTH;

    typedef logic [BHSR_WIDTH-1:0] idx_t;

    ctr_t       pht_q [ENTRIES];
    btb_entry_t btb_q [ENTRIES];

    idx_t             if_idx, if_pht_idx, upd_idx, upd_pht_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    btb_entry_t       if_entry;
    ctr_t             if_ctr, upd_ctr;
    logic             if_hit;

    ctr_t       pht_d;
    btb_entry_t btb_d;
    logic       pht_we, btb_we;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{pc_if[1:0], upd_pc[1:0]};

    assign if_idx      = pc_if[BHSR_WIDTH+1:2];
    assign if_pht_idx  = if_idx ^ bhsr_in;
    assign if_tag      = tag_of(pc_if, BHSR_WIDTH);
    assign upd_idx     = upd_pc[BHSR_WIDTH+1:2];
    assign upd_pht_idx = upd_idx ^ upd_bhsr;
    assign upd_tag     = tag_of(upd_pc, BHSR_WIDTH);

    assign if_entry = btb_q[if_idx];
    assign if_ctr   = pht_q[if_pht_idx];
    assign upd_ctr  = pht_q[upd_pht_idx];

    // Fetch-side prediction over the current (pre-update) table contents.
    always_comb begin
        if_hit     = if_entry.valid && (if_entry.tag == if_tag);
        pred_taken = if_hit && (if_entry.is_jump || if_ctr[1]);
        next_pc    = pred_taken ? if_entry.target : (pc_if + 32'd4);
    end

    // History shift control mirrors the resolved conditional branch.
    always_comb begin
        bhsr_upd_en = upd_en && !upd_is_jump;
        bhsr_taken  = upd_taken;
    end

    sat_counter2 u_sat (
        .cnt_i   (upd_ctr),
        .taken_i (upd_taken),
        .cnt_o   (pht_d)
    );

    // Write enables and the BTB entry to install for this update.
    always_comb begin
        pht_we        = upd_en && !upd_is_jump;
        btb_we        = upd_en && (upd_is_jump || upd_taken);
        btb_d.valid   = 1'b1;
        btb_d.tag     = upd_tag;
        btb_d.target  = upd_target;
        btb_d.is_jump = upd_is_jump;
    end

    // Table storage; reset wins over any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i]       <= WNT;
                btb_q[i].valid <= 1'b0;
            end
        end else begin
            if (pht_we) pht_q[upd_pht_idx] <= pht_d;
            if (btb_we) btb_q[upd_idx]     <= btb_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with hand-computed expectations.
// With BHSR_WIDTH=5: 0x100, 0x180 and 0x200 all map to index 0;
// tags are 2, 3 and 4 respectively. 0x104 is index 1, 0x10C is index 3.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_if;
    logic [4:0]  bhsr_in;
    logic        pred_taken;
    logic [31:0] next_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [4:0]  upd_bhsr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_is_jump;
    logic        bhsr_upd_en;
    logic        bhsr_taken;

    int checks = 0;
    int errors = 0;

    gshare_predictor #(.BHSR_WIDTH(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_if       (pc_if),
        .bhsr_in     (bhsr_in),
        .pred_taken  (pred_taken),
        .next_pc     (next_pc),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_bhsr    (upd_bhsr),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_is_jump (upd_is_jump),
        .bhsr_upd_en (bhsr_upd_en),
        .bhsr_taken  (bhsr_taken)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_upd(input logic en, input logic [31:0] pc, input logic [4:0] bh,
                             input logic tk, input logic [31:0] tgt, input logic jmp);
        upd_en      = en;
        upd_pc      = pc;
        upd_bhsr    = bh;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_is_jump = jmp;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
        pc_if = 32'h100; bhsr_in = 5'd0;
        tick(); tick();
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", pred_taken); end
        checks++; if (next_pc !== 32'h104) begin errors++; $display("FAIL reset_next: got %h want 00000104", next_pc); end
        checks++; if (bhsr_upd_en !== 1'b0) begin errors++; $display("FAIL reset_bhsr_en: got %0b want 0", bhsr_upd_en); end
        pc_if = 32'hFFFF_FFFC; #1;
        checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 00000000", next_pc); end
        reset = 1'b0;
        pc_if = 32'h100;
        tick();
    endtask

    task automatic test_branch_taken;
        drive_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
        pc_if = 32'h100; bhsr_in = 5'd0; #1;
        checks++; if (bhsr_upd_en !== 1'b1) begin errors++; $display("FAIL br_bhsr_en: got %0b want 1", bhsr_upd_en); end
        checks++; if (bhsr_taken !== 1'b1) begin errors++; $display("FAIL br_bhsr_taken: got %0b want 1", bhsr_taken); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL br_pre_pred: got %0b want 0", pred_taken); end
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL br_pred: got %0b want 1", pred_taken); end
        checks++; if (next_pc !== 32'h80) begin errors++; $display("FAIL br_next: got %h want 00000080", next_pc); end
    endtask

    // Counter at index 0 goes 10 -> 11, then five not-taken: 10,01,00,00,00.
    task automatic test_saturate;
        logic        exp_pred [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp_next [5] = '{32'h80, 32'h104, 32'h104, 32'h104, 32'h104};
        drive_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive_upd(1'b1, 32'h100, 5'd0, 1'b0, 32'h0, 1'b0); #1;
            if (k == 0) begin
                checks++; if (bhsr_taken !== 1'b0) begin errors++; $display("FAIL nt_bhsr_taken: got %0b want 0", bhsr_taken); end
            end
            tick();
            drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
            checks++; if (pred_taken !== exp_pred[k]) begin errors++; $display("FAIL sat_pred[%0d]: got %0b want %0b", k, pred_taken, exp_pred[k]); end
            checks++; if (next_pc !== exp_next[k]) begin errors++; $display("FAIL sat_next[%0d]: got %h want %h", k, next_pc, exp_next[k]); end
        end
        // Floor check: one taken from 00 gives 01, still not taken.
        drive_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor: got %0b want 0", pred_taken); end
        drive_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_recover: got %0b want 1", pred_taken); end
    endtask

    // PHT[0]=10, PHT[3]=01, BTB[0] = tag 2 -> 0x80.
    task automatic test_history_tag;
        pc_if = 32'h100; bhsr_in = 5'b00011; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL hist_pred: got %0b want 0", pred_taken); end
        checks++; if (next_pc !== 32'h104) begin errors++; $display("FAIL hist_next: got %h want 00000104", next_pc); end
        pc_if = 32'h180; bhsr_in = 5'd0; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL tag_miss_pred: got %0b want 0", pred_taken); end
        checks++; if (next_pc !== 32'h184) begin errors++; $display("FAIL tag_miss_next: got %h want 00000184", next_pc); end
    endtask

    // Jump reported with upd_taken=0 so a wrongful PHT write would decrement PHT[0].
    task automatic test_jump;
        drive_upd(1'b1, 32'h200, 5'd0, 1'b0, 32'h400, 1'b1);
        pc_if = 32'h200; bhsr_in = 5'd0; #1;
        checks++; if (bhsr_upd_en !== 1'b0) begin errors++; $display("FAIL jmp_bhsr_en: got %0b want 0", bhsr_upd_en); end
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
        pc_if = 32'h200; bhsr_in = 5'h1A; #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jmp_pred: got %0b want 1", pred_taken); end
        checks++; if (next_pc !== 32'h400) begin errors++; $display("FAIL jmp_next: got %h want 00000400", next_pc); end
        pc_if = 32'h100; bhsr_in = 5'd0; #1;
        checks++; if (next_pc !== 32'h104) begin errors++; $display("FAIL evict_next: got %h want 00000104", next_pc); end
        // PHT[0] must still be 10: taken -> 11, not-taken -> 10 (taken).
        drive_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
        tick();
        drive_upd(1'b1, 32'h100, 5'd0, 1'b0, 32'h0, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jmp_no_pht: got %0b want 1", pred_taken); end
        checks++; if (next_pc !== 32'h80) begin errors++; $display("FAIL jmp_reinstall: got %h want 00000080", next_pc); end
    endtask

    task automatic test_back_to_back;
        drive_upd(1'b1, 32'h104, 5'd0, 1'b1, 32'h300, 1'b0);
        pc_if = 32'h104; bhsr_in = 5'd0; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cyc_pred: got %0b want 0", pred_taken); end
        checks++; if (next_pc !== 32'h108) begin errors++; $display("FAIL same_cyc_next: got %h want 00000108", next_pc); end
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL next_cyc_pred: got %0b want 1", pred_taken); end
        checks++; if (next_pc !== 32'h300) begin errors++; $display("FAIL next_cyc_next: got %h want 00000300", next_pc); end
    endtask

    task automatic test_reset_priority;
        reset = 1'b1;
        drive_upd(1'b1, 32'h104, 5'd0, 1'b1, 32'h500, 1'b0);
        tick();
        pc_if = 32'h104; bhsr_in = 5'd0; #1;
        checks++; if (next_pc !== 32'h108) begin errors++; $display("FAIL rst_pri_next: got %h want 00000108", next_pc); end
        pc_if = 32'h100; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_clear_pred: got %0b want 0", pred_taken); end
        reset = 1'b0;
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
        tick();
        // PHT[0] back at 01: taken -> 10 (taken), not-taken -> 01 (not taken).
        drive_upd(1'b1, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL rst_pht_a: got %0b want 1", pred_taken); end
        drive_upd(1'b1, 32'h100, 5'd0, 1'b0, 32'h0, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0); #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pht_b: got %0b want 0", pred_taken); end
        checks++; if (next_pc !== 32'h104) begin errors++; $display("FAIL rst_pht_next: got %h want 00000104", next_pc); end
    endtask

    // 0x10C (idx 3) with history 3 trains PHT[0]; history 0 reads PHT[3].
    task automatic test_xor_index;
        drive_upd(1'b1, 32'h10C, 5'd3, 1'b1, 32'h600, 1'b0);
        tick();
        drive_upd(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
        pc_if = 32'h10C; bhsr_in = 5'd3; #1;
        checks++; if (next_pc !== 32'h600) begin errors++; $display("FAIL xor_hit_next: got %h want 00000600", next_pc); end
        bhsr_in = 5'd0; #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL xor_other_pred: got %0b want 0", pred_taken); end
        checks++; if (next_pc !== 32'h110) begin errors++; $display("FAIL xor_other_next: got %h want 00000110", next_pc); end
    endtask

    initial begin
        test_reset();
        test_branch_taken();
        test_saturate();
        test_history_tag();
        test_jump();
        test_back_to_back();
        test_reset_priority();
        test_xor_index();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
